// File: rtl/uc_boot_pkg.sv
// Shared types and constants for the program-load stage (uc_boot_loader).
// Program memory geometry, frame marker, state encoding and word type.
package uc_boot_pkg;

    localparam int         ADDR_W    = 12;
    localparam int         CNT_W     = ADDR_W + 1;
    localparam int         MAX_WORDS = 2 ** ADDR_W;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [15:0] boot_word_t;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LEN_H  = 4'd1,
        LEN_L  = 4'd2,
        DATA_H = 4'd3,
        DATA_L = 4'd4,
        WRITE  = 4'd5,
        CSUM   = 4'd6,
        DONE   = 4'd7,
        ERR    = 4'd8
    } boot_state_e;

    // An image longer than program memory can never be loaded.
    function automatic logic len_too_long(input logic [15:0] len);
        return len > 16'(MAX_WORDS);
    endfunction

endpackage

// File: rtl/uc_boot_word_asm.sv
// Pairs the high and low bytes of an instruction into one boot_word_t.
// The high byte is parked in a register; the word is presented, with
// word_valid, in the same cycle the low byte is accepted.
module uc_boot_word_asm
    import uc_boot_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic       hi_load,
    input  logic       lo_load,
    input  logic [7:0] byte_in,
    output boot_word_t word,
    output logic       word_valid
);

    logic [7:0] hi_q;

    // Hold the high byte until its partner arrives.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hi_q <= '0;
        end else if (hi_load) begin
            hi_q <= byte_in;
        end
    end

    // The low byte completes the word on the cycle it is accepted.
    always_comb begin
        word       = {hi_q, byte_in};
        word_valid = lo_load;
    end

endmodule

// File: rtl/uc_boot_loader.sv
// Program-load stage for the 8-bit microcontroller core.
// Takes a framed byte stream (SYNC, LEN_H, LEN_L, LEN words hi/lo, optional
// CSUM), writes the words to program memory from address 0 upward and keeps
// the core in bootstrapping until a complete image has landed.
// Build option: define UC_BOOT_CHECKSUM_EN to require a trailing CSUM byte
// whose 8-bit sum with LEN_H, LEN_L and all data bytes is zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for SYNC, other bytes dropped
// LEN_H  | expecting length high byte
// LEN_L  | expecting length low byte, range check
// DATA_H | expecting instruction high byte
// DATA_L | expecting instruction low byte
// WRITE  | prog_we held until prog_ack, byte input stalled
// CSUM   | expecting checksum byte (checksum build only)
// DONE   | image loaded, core released, terminal until reset
// ERR    | bad length or checksum, waiting for SYNC
module uc_boot_loader
    import uc_boot_pkg::*;
(
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              prog_we,
    input  logic              prog_ack,
    output logic [ADDR_W-1:0] prog_addr,
    output boot_word_t        prog_wdata,
    output logic              bootstrapping,
    output logic              boot_done,
    output logic              boot_error
);

`ifdef UC_BOOT_CHECKSUM_EN
    localparam boot_state_e TAIL_STATE = CSUM;
`else
    localparam boot_state_e TAIL_STATE = DONE;
`endif

    boot_state_e      state_q;
    boot_state_e      state_nx;
    logic             rx_accept;
    logic             is_sync;
    logic             last_word;
    logic             hi_load;
    logic             lo_load;
    logic [7:0]       len_h_q;
    logic [15:0]      len_w;
    logic [CNT_W-1:0] words_left;
    boot_word_t       asm_word;
    logic             asm_valid;
    logic             csum_ok;

    assign is_sync   = (rx_data == SYNC_BYTE);
    assign len_w     = {len_h_q, rx_data};
    assign last_word = (words_left == CNT_W'(1));
    assign hi_load   = rx_accept && (state_q == DATA_H);
    assign lo_load   = rx_accept && (state_q == DATA_L);

    uc_boot_word_asm u_word_asm (
        .clk        (clk),
        .arst_n     (arst_n),
        .hi_load    (hi_load),
        .lo_load    (lo_load),
        .byte_in    (rx_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

`ifdef UC_BOOT_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_total;

    assign sum_total = sum_q + rx_data;
    assign csum_ok   = (sum_total == 8'h00);

    // Running sum of every byte after SYNC; restarted by each SYNC.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sum_q <= '0;
        end else if (rx_accept) begin
            case (state_q)
                IDLE, ERR: if (is_sync) sum_q <= '0;
                LEN_H, LEN_L, DATA_H, DATA_L: sum_q <= sum_total;
                default: ;
            endcase
        end
    end
`else
    // CSUM is unreachable in this build; any path into it would fail.
    assign csum_ok = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Moore outputs from state, then next-state from the accepted byte.
    always_comb begin
        state_nx      = state_q;
        rx_ready      = 1'b1;
        prog_we       = 1'b0;
        bootstrapping = 1'b1;
        boot_done     = 1'b0;
        boot_error    = 1'b0;

        case (state_q)
            WRITE: begin
                rx_ready = 1'b0;
                prog_we  = 1'b1;
            end
            DONE: begin
                rx_ready      = 1'b0;
                bootstrapping = 1'b0;
                boot_done     = 1'b1;
            end
            ERR:     boot_error = 1'b1;
            default: ;
        endcase

        rx_accept = rx_valid && rx_ready;

        case (state_q)
            IDLE: if (rx_accept && is_sync) state_nx = LEN_H;
            LEN_H: if (rx_accept) state_nx = LEN_L;
            LEN_L: begin
                if (rx_accept) begin
                    if (len_too_long(len_w)) begin
                        state_nx = ERR;
                    end else if (len_w == 16'h0000) begin
                        state_nx = TAIL_STATE;
                    end else begin
                        state_nx = DATA_H;
                    end
                end
            end
            DATA_H: if (rx_accept) state_nx = DATA_L;
            DATA_L: if (rx_accept) state_nx = WRITE;
            WRITE: if (prog_ack) state_nx = last_word ? TAIL_STATE : DATA_H;
            CSUM: if (rx_accept) state_nx = csum_ok ? DONE : ERR;
            DONE: state_nx = DONE;
            ERR: if (rx_accept && is_sync) state_nx = LEN_H;
            default: state_nx = IDLE;
        endcase
    end

    // Length capture, word countdown, write address and write data.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            len_h_q    <= '0;
            words_left <= '0;
            prog_addr  <= '0;
            prog_wdata <= '0;
        end else begin
            if (rx_accept) begin
                case (state_q)
                    IDLE, ERR: if (is_sync) prog_addr <= '0;
                    LEN_H: len_h_q <= rx_data;
                    LEN_L: begin
                        prog_addr  <= '0;
                        words_left <= len_w[CNT_W-1:0];
                    end
                    default: ;
                endcase
            end
            if (asm_valid) begin
                prog_wdata <= asm_word;
            end
            if ((state_q == WRITE) && prog_ack) begin
                words_left <= words_left - CNT_W'(1);
                // A full-size image ends at the top address; stay there rather than wrap.
                if (prog_addr != '1) begin
                    prog_addr <= prog_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
